rand_traffic_gen: RTL

Synthesisable, parametrised multi-channel random traffic source for driving FIFOs and mesh routers in hardware rather than from a testbench.
- Each channel makes an independent Bernoulli arrival decision every enabled cycle from its own LFSR, against a programmable rate.
- Each arrival carries pseudo-random payload and a per-channel sequence number, and is buffered in a small per-channel source queue.
- Queue contents are presented on a valid/ready interface.
- Arrivals that hit a full queue are dropped and counted, so the sink can measure offered versus accepted load.

---
 rtl/rand_traffic_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rand_traffic_gen.sv
// Multi-channel Bernoulli traffic source: per-channel LFSR arrivals, FIFO source queues, drop counters.
// Define RAND_TRAFFIC_TIMESTAMP_EN to stamp each queued entry with a free-running cycle count on ts_out.
module rand_traffic_gen #(
  parameter int          WIDTH    = 8,
  parameter int          CHANNELS = 4,
  parameter int          QDEPTH   = 4,
  parameter int          SEQ_W    = 16,
  parameter int          TS_W     = 16,
  parameter logic [31:0] SEED     = 32'h00000007
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [16:0]               rate,
  output logic [CHANNELS-1:0]       valid,
  input  logic [CHANNELS-1:0]       ready,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS*SEQ_W-1:0] seq_out,
  output logic [CHANNELS*TS_W-1:0]  ts_out,
  output logic [CHANNELS*16-1:0]    drop_cnt
);

  localparam int          PW     = $clog2(QDEPTH);
  localparam int          CW     = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);
  localparam logic [31:0] GOLDEN = 32'h9E3779B9;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], x[0] ^ x[1] ^ x[21] ^ x[31]};
  endfunction

  // An all-zero LFSR would lock up, so such seeds are forced to 1.
  function automatic logic [31:0] nonzero(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

`ifdef RAND_TRAFFIC_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_W'(1);
  end
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [31:0] A_RAW  = SEED + 32'(c) * GOLDEN;
    localparam logic [31:0] A_SEED = nonzero(A_RAW);
    localparam logic [31:0] D_SEED = nonzero(~A_RAW);

    logic [31:0]      a_lfsr;
    logic [31:0]      d_lfsr;
    logic [SEQ_W-1:0] seq;
    logic [15:0]      drops;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] data_mem [QDEPTH];
    logic [SEQ_W-1:0] seq_mem  [QDEPTH];
    logic             arrive;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // A pop in the same cycle frees a slot, so a full queue still accepts that arrival.
    always_comb begin
      arrive = enable && ({1'b0, a_lfsr[15:0]} < rate);
      full   = (count == FULL);
      pop    = (count != '0) && ready[c];
      push   = arrive && (!full || pop);
      drop   = arrive && full && !pop;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_lfsr <= A_SEED;
        d_lfsr <= D_SEED;
      end else if (enable) begin
        a_lfsr <= lfsr_step(a_lfsr);
        d_lfsr <= lfsr_step(d_lfsr);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        seq   <= '0;
        drops <= '0;
      end else begin
        if (arrive)
          seq <= seq + SEQ_W'(1);
        if (drop && drops != 16'hFFFF)
          drops <= drops + 16'd1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)
          count <= count + CW'(1);
        else if (pop && !push)
          count <= count - CW'(1);
      end
    end

    // Storage is cleared on reset so the head outputs read zero; WIDTH is assumed <= 32.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < QDEPTH; i++) begin
          data_mem[i] <= '0;
          seq_mem[i]  <= '0;
        end
      end else if (push) begin
        data_mem[wr_ptr] <= d_lfsr[WIDTH-1:0];
        seq_mem[wr_ptr]  <= seq;
      end
    end

    assign valid[c]                    = (count != '0);
    assign data_out[c*WIDTH +: WIDTH]  = data_mem[rd_ptr];
    assign seq_out[c*SEQ_W +: SEQ_W]   = seq_mem[rd_ptr];
    assign drop_cnt[c*16 +: 16]        = drops;

`ifdef RAND_TRAFFIC_TIMESTAMP_EN
    logic [TS_W-1:0] ts_mem [QDEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < QDEPTH; i++)
          ts_mem[i] <= '0;
      end else if (push) begin
        ts_mem[wr_ptr] <= ts_cnt;
      end
    end

    assign ts_out[c*TS_W +: TS_W] = ts_mem[rd_ptr];
`else
    assign ts_out[c*TS_W +: TS_W] = '0;
`endif
  end

endmodule
